// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Fetch-stage PC generator feeding the Fetch->Decode register.
//               Owns the program counter and an optional direct-mapped BTB
//               with 2-bit saturating counters.  It also resolves branches
//               returned from Execute, flags mispredictions and redirects.
//
// Build option: FETCH_BTB_EN
//               defined   - BTB lookup/update and predicted-taken fetch.
//               undefined - no BTB storage.  Prediction outputs are tied to 0,
//                           and every taken branch redirects.
//
// Ports       : CLK, RESETn          clock, async active-low reset
//               StallF, MCycleBusy   hold PC / freeze all state
//               PCF                  current fetch PC
//               PredictedTakenF      BTB predicts PCF is a taken branch
//               PredictedBTAF        predicted target (0 when not taken)
//               BranchE, TakenE, PCE, TargetE,
//               PredictedTakenE, PredictedBTAE   resolution from Execute
//               RedirectE            misprediction, correct PC goes next
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        StallF,
    input  logic        MCycleBusy,
    output logic [31:0] PCF,
    output logic        PredictedTakenF,
    output logic [31:0] PredictedBTAF,
    input  logic        BranchE,
    input  logic        TakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] TargetE,
    input  logic        PredictedTakenE,
    input  logic [31:0] PredictedBTAE,
    output logic        RedirectE
);

    localparam int IDX = $clog2(BTB_ENTRIES);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] correct_pc;
    logic        pred_taken;
    logic [31:0] pred_bta;
    logic        redirect;

    assign correct_pc = (BranchE && TakenE) ? TargetE : (PCE + 32'd4);

`ifdef FETCH_BTB_EN
    localparam int TAGW = 30 - IDX;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]        tag_q [BTB_ENTRIES];
    logic [31:0]            tgt_q [BTB_ENTRIES];
    logic [1:0]             ctr_q [BTB_ENTRIES];

    logic [IDX-1:0]  idx_f;
    logic [TAGW-1:0] tag_f;
    logic [IDX-1:0]  idx_e;
    logic [TAGW-1:0] tag_e;
    logic            hit_f;
    logic            hit_e;
    logic            upd_e;

    assign idx_f = pc_q[IDX+1:2];
    assign tag_f = pc_q[31:IDX+2];
    assign idx_e = PCE[IDX+1:2];
    assign tag_e = PCE[31:IDX+2];

    // Lookup reads the registered arrays, so a same-cycle update to the
    // same index only becomes visible on the following cycle.
    assign hit_f      = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pred_taken = hit_f && ctr_q[idx_f][1];
    assign pred_bta   = pred_taken ? tgt_q[idx_f] : 32'd0;

    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign upd_e = BranchE && !MCycleBusy;

    // A branch is mispredicted on a direction mismatch, on a wrong target
    // for a taken branch, or when a non-branch was predicted taken.
    assign redirect = (BranchE && ((TakenE != PredictedTakenE) ||
                                   (TakenE && (TargetE != PredictedBTAE)))) ||
                      (!BranchE && PredictedTakenE);

    // Only the valid bits are reset; payload is qualified by valid.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            valid_q <= '0;
        end else if (upd_e && !hit_e && TakenE) begin
            valid_q[idx_e] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (upd_e) begin
            if (hit_e) begin
                if (TakenE) begin
                    tgt_q[idx_e] <= TargetE;
                    if (ctr_q[idx_e] != 2'd3) begin
                        ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
                    end
                end else if (ctr_q[idx_e] != 2'd0) begin
                    ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
                end
            end else if (TakenE) begin
                // Fresh allocations start weakly taken.
                tag_q[idx_e] <= tag_e;
                tgt_q[idx_e] <= TargetE;
                ctr_q[idx_e] <= 2'd2;
            end
        end
    end
`else
    logic           unused_pred;
    logic [IDX-1:0] unused_idx;

    assign unused_pred = ^{PredictedTakenE, PredictedBTAE};
    assign unused_idx  = pc_q[IDX+1:2];

    assign pred_taken = 1'b0;
    assign pred_bta   = 32'd0;
    // With no prediction, every taken branch leaves the sequential path.
    assign redirect   = BranchE && TakenE;
`endif

    // Next-PC priority: freeze, redirect (beats stall), stall, predict, +4.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (MCycleBusy) begin
            pc_d = pc_q;
        end else if (redirect) begin
            pc_d = correct_pc;
        end else if (StallF) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_bta;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PCF             = pc_q;
    assign PredictedTakenF = pred_taken;
    assign PredictedBTAF   = pred_bta;
    assign RedirectE       = redirect;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Directed, table-driven bench for fetch_pc_unit.  Each record
//               holds the Execute/hazard inputs for one cycle, the expected
//               combinational outputs before the edge and the expected PCF
//               after it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

`ifdef FETCH_BTB_EN
    localparam bit C_BTB = 1'b1;
`else
    localparam bit C_BTB = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        StallF = 1'b0;
    logic        MCycleBusy = 1'b0;
    logic [31:0] PCF;
    logic        PredictedTakenF;
    logic [31:0] PredictedBTAF;
    logic        BranchE = 1'b0;
    logic        TakenE = 1'b0;
    logic [31:0] PCE = 32'd0;
    logic [31:0] TargetE = 32'd0;
    logic        PredictedTakenE = 1'b0;
    logic [31:0] PredictedBTAE = 32'd0;
    logic        RedirectE;

    int nchk = 0;
    int nerr = 0;

    fetch_pc_unit #(
        .RESET_PC    (32'h0000_0000),
        .BTB_ENTRIES (16)
    ) dut (
        .CLK             (CLK),
        .RESETn          (RESETn),
        .StallF          (StallF),
        .MCycleBusy      (MCycleBusy),
        .PCF             (PCF),
        .PredictedTakenF (PredictedTakenF),
        .PredictedBTAF   (PredictedBTAF),
        .BranchE         (BranchE),
        .TakenE          (TakenE),
        .PCE             (PCE),
        .TargetE         (TargetE),
        .PredictedTakenE (PredictedTakenE),
        .PredictedBTAE   (PredictedBTAE),
        .RedirectE       (RedirectE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        stall;
        logic        busy;
        logic        br;
        logic        tk;
        logic [31:0] pce;
        logic [31:0] tgt;
        logic        pte;
        logic [31:0] pbta;
        logic        exp_red;
        logic        exp_ptf;
        logic [31:0] exp_bta;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic stall, input logic busy,
                                input logic br, input logic tk,
                                input logic [31:0] pce, input logic [31:0] tgt,
                                input logic pte, input logic [31:0] pbta,
                                input logic red, input logic [31:0] pc);
        vec_t v;
        v.stall = stall; v.busy = busy; v.br = br; v.tk = tk;
        v.pce = pce; v.tgt = tgt; v.pte = pte; v.pbta = pbta;
        v.exp_red = red; v.exp_ptf = 1'b0; v.exp_bta = 32'd0; v.exp_pc = pc;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge: drive, check combinational outputs, take one
    // posedge, check the new PCF, return at the next negedge.
    task automatic step(input string nm, input vec_t v);
        StallF = v.stall; MCycleBusy = v.busy; BranchE = v.br; TakenE = v.tk;
        PCE = v.pce; TargetE = v.tgt; PredictedTakenE = v.pte; PredictedBTAE = v.pbta;
        #1;
        check({nm, ".RedirectE"}, {31'd0, RedirectE}, {31'd0, v.exp_red});
        check({nm, ".PredictedTakenF"}, {31'd0, PredictedTakenF}, {31'd0, v.exp_ptf});
        check({nm, ".PredictedBTAF"}, PredictedBTAF, v.exp_bta);
        @(posedge CLK);
        #1;
        check({nm, ".PCF"}, PCF, v.exp_pc);
        @(negedge CLK);
    endtask

    vec_t idle;
    vec_t tbl [16];
    vec_t v;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle = mk(0,0,0,0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);

        //            stall busy br tk  PCE           TargetE       pte PBTAE  red PCF after
        tbl[0]  = mk(0,0,0,0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h0000_0004);
        tbl[1]  = mk(0,0,0,0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h0000_0008);
        tbl[2]  = mk(1,0,0,0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h0000_0008);
        tbl[3]  = mk(0,0,1,1, 32'h10,       32'h100,      0, 32'h0, 1, 32'h0000_0100);
        tbl[4]  = mk(0,0,0,0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h0000_0104);
        tbl[5]  = mk(0,0,1,0, 32'h20,       32'h999,      0, 32'h0, 0, 32'h0000_0108);
        tbl[6]  = mk(1,0,1,1, 32'h30,       32'h200,      0, 32'h0, 1, 32'h0000_0200);
        tbl[7]  = mk(0,1,1,1, 32'h48,       32'h300,      0, 32'h0, 1, 32'h0000_0200);
        tbl[8]  = mk(0,1,0,0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h0000_0200);
        tbl[9]  = mk(0,0,1,1, 32'h48,       32'h300,      0, 32'h0, 1, 32'h0000_0300);
        tbl[10] = mk(1,1,0,0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h0000_0300);
        tbl[11] = mk(0,0,1,1, 32'h50,       32'hFFFF_FFFC,0, 32'h0, 1, 32'hFFFF_FFFC);
        tbl[12] = mk(0,0,0,0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h0000_0000);
        tbl[13] = mk(0,0,0,0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h0000_0004);
        tbl[14] = mk(0,0,1,0, 32'hFFFF_FFFC,32'h0,        0, 32'h0, 0, 32'h0000_0008);
        tbl[15] = mk(0,0,1,1, 32'h60,       32'h40,       0, 32'h0, 1, 32'h0000_0040);

        // Power-on reset
        #3;
        check("reset.PCF", PCF, 32'h0);
        check("reset.PredictedTakenF", {31'd0, PredictedTakenF}, 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Asynchronous reset mid-run from PCF=0x40
        check("pre_reset.PCF", PCF, 32'h40);
        RESETn = 1'b0;
        #1;
        check("async_reset.PCF", PCF, 32'h0);
        check("async_reset.PredictedTakenF", {31'd0, PredictedTakenF}, 32'd0);
        @(posedge CLK);
        #1;
        check("held_reset.PCF", PCF, 32'h0);
        @(negedge CLK);
        RESETn = 1'b1;
        v = idle; v.exp_pc = 32'h4; step("post_reset1", v);
        v = idle; v.exp_pc = 32'h8; step("post_reset2", v);

        // Non-branch carrying a taken prediction, PCF=0x8
        v = mk(0,0,0,0, 32'h70, 32'h0, 1, 32'h0, C_BTB,
               C_BTB ? 32'h74 : 32'h0C);
        step("nonbranch_pred", v);
        // Taken branch whose prediction was fully correct
        v = mk(0,0,1,1, 32'h74, 32'h500, 1, 32'h500, !C_BTB,
               C_BTB ? 32'h78 : 32'h500);
        step("correct_pred", v);

`ifdef FETCH_BTB_EN
        // Cold taken branch allocates; later fetch of 0x10 predicts 0x100
        step("cold_taken", mk(0,0,1,1, 32'h10, 32'h100, 0, 32'h0, 1, 32'h100));
        step("goto_10",    mk(0,0,1,1, 32'h80, 32'h10,  0, 32'h0, 1, 32'h10));
        v = idle; v.exp_ptf = 1; v.exp_bta = 32'h100; v.exp_pc = 32'h100;
        step("predict_10", v);
        // Counter decay 2->1 on a not-taken resolution
        step("decay", mk(0,0,1,0, 32'h10, 32'h0, 1, 32'h100, 1, 32'h14));
        step("goto_10b", mk(0,0,1,1, 32'hA0, 32'h10, 0, 32'h0, 1, 32'h10));
        v = idle; v.exp_pc = 32'h14; step("weak_10", v);
        // Wrong target: tgt becomes 0x300, ctr back to 2
        step("wrong_tgt", mk(0,0,1,1, 32'h10, 32'h300, 1, 32'h200, 1, 32'h300));
        step("goto_10c", mk(0,0,1,1, 32'hA0, 32'h10, 0, 32'h0, 1, 32'h10));
        // Busy freezes PC and BTB, redirect applies once busy drops
        v = mk(0,1,1,0, 32'h10, 32'h0, 1, 32'h300, 1, 32'h10);
        v.exp_ptf = 1; v.exp_bta = 32'h300; step("busy_redirect", v);
        v = mk(0,0,1,0, 32'h10, 32'h0, 1, 32'h300, 1, 32'h14);
        v.exp_ptf = 1; v.exp_bta = 32'h300; step("busy_release", v);
        step("goto_10d", mk(0,0,1,1, 32'hA0, 32'h10, 0, 32'h0, 1, 32'h10));
        v = idle; v.exp_pc = 32'h14; step("weak_10b", v);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
